// File: rtl/rtc_bus_responder.sv
// Responder end of the multiplexed RTC parallel bus: samples the active-low A/D, CS,
// WR and RD strobes and serves bus reads/writes to a byte register file shared with a local port.
module rtc_bus_responder #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_a_d,
  input  logic              in_cs,
  input  logic              in_wr,
  input  logic              in_rd,
  input  logic [7:0]        in_dato,
  output logic [7:0]        out_dato,
  output logic              out_oe,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic              loc_we,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              out_flag_wr_done,
  output logic              out_flag_rd_done,
  output logic              out_flag_error
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_VALID,
    WRITE,
    READ,
    ERR
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                s_a_d;
  logic                s_cs;
  logic                s_wr;
  logic                s_rd;
  logic [DATA_W-1:0]   s_dato;

  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   regfile [DEPTH];

  logic                addr_load;
  logic                data_load;
  logic                commit;
  logic                err_set;
  logic                rd_done_set;
  logic                dbl_strobe;

  logic [ADDR_W-1:0]   idx;
  logic                addr_oor;
  logic                bus_wr_en;
  logic [DATA_W-1:0]   rd_fwd;
  logic [DATA_W-1:0]   rd_val;

  assign idx       = addr_q[ADDR_W-1:0];
  assign addr_oor  = (addr_q >> ADDR_W) != 8'h00;
  assign bus_wr_en = commit && !addr_oor;
  assign loc_rdata = regfile[loc_addr];

  // A local write landing on the entry being read shows up on the bus at once.
  assign rd_fwd = (loc_we && (loc_addr == idx)) ? loc_wdata : regfile[idx];
  assign rd_val = addr_oor ? 8'h00 : rd_fwd;

  // Single register stage on every bus pin; the FSM only looks at these.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_a_d  <= 1'b1;
      s_cs   <= 1'b1;
      s_wr   <= 1'b1;
      s_rd   <= 1'b1;
      s_dato <= '0;
    end else begin
      s_a_d  <= in_a_d;
      s_cs   <= in_cs;
      s_wr   <= in_wr;
      s_rd   <= in_rd;
      s_dato <= in_dato;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_load   = 1'b0;
    data_load   = 1'b0;
    commit      = 1'b0;
    err_set     = 1'b0;
    rd_done_set = 1'b0;
    dbl_strobe  = !s_cs && !s_wr && !s_rd;

    // WR and RD low together is a protocol violation from any live state.
    if (dbl_strobe && (state != ERR)) begin
      err_set   = 1'b1;
      state_nxt = ERR;
    end else begin
      case (state)
        IDLE: begin
          if (!s_cs) begin
            if (!s_a_d && !s_wr) begin
              state_nxt = ADDR;
              addr_load = 1'b1;
            end else if (s_a_d && (!s_wr || !s_rd)) begin
              err_set   = 1'b1;
              state_nxt = ERR;
            end
          end
        end
        ADDR: begin
          if (s_cs) begin
            state_nxt = IDLE;
          end else if (s_wr) begin
            state_nxt = ADDR_VALID;
          end else begin
            addr_load = 1'b1;
          end
        end
        ADDR_VALID: begin
          if (!s_cs) begin
            if (s_a_d && !s_wr) begin
              state_nxt = WRITE;
              data_load = 1'b1;
            end else if (s_a_d && !s_rd) begin
              state_nxt = READ;
            end else if (!s_a_d && !s_wr) begin
              state_nxt = ADDR;
              addr_load = 1'b1;
            end
          end
        end
        WRITE: begin
          if (s_wr || s_cs) begin
            commit    = 1'b1;
            state_nxt = ADDR_VALID;
          end else begin
            data_load = 1'b1;
          end
        end
        READ: begin
          if (s_rd || s_cs) begin
            rd_done_set = 1'b1;
            state_nxt   = ADDR_VALID;
          end
        end
        ERR: begin
          if (s_cs) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (addr_load) begin
        addr_q <= s_dato;
      end
      if (data_load) begin
        data_q <= s_dato;
      end
    end
  end

  // Bus commit wins a same-index collision with the local port.
  always_ff @(posedge clk) begin
    if (reset) begin
      regfile <= '{default: '0};
    end else begin
      if (bus_wr_en) begin
        regfile[idx] <= data_q;
      end
      if (loc_we && !(bus_wr_en && (loc_addr == idx))) begin
        regfile[loc_addr] <= loc_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_oe           <= 1'b0;
      out_dato         <= '0;
      out_flag_wr_done <= 1'b0;
      out_flag_rd_done <= 1'b0;
      out_flag_error   <= 1'b0;
    end else begin
      out_oe           <= (state_nxt == READ);
      out_dato         <= (state_nxt == READ) ? rd_val : 8'h00;
      out_flag_wr_done <= commit;
      out_flag_rd_done <= rd_done_set;
      out_flag_error   <= err_set;
    end
  end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: directed protocol scenarios plus randomized bus and
// local-port traffic scored against a plain byte-array model of the register file.
module tb_rtc_bus_responder;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_a_d;
  logic              in_cs;
  logic              in_wr;
  logic              in_rd;
  logic [7:0]        in_dato;
  logic [7:0]        out_dato;
  logic              out_oe;
  logic [ADDR_W-1:0] loc_addr;
  logic              loc_we;
  logic [7:0]        loc_wdata;
  logic [7:0]        loc_rdata;
  logic              out_flag_wr_done;
  logic              out_flag_rd_done;
  logic              out_flag_error;

  logic [7:0] model_rf [DEPTH];
  logic [7:0] cur_addr;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  rtc_bus_responder #(.ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_a_d           (in_a_d),
    .in_cs            (in_cs),
    .in_wr            (in_wr),
    .in_rd            (in_rd),
    .in_dato          (in_dato),
    .out_dato         (out_dato),
    .out_oe           (out_oe),
    .loc_addr         (loc_addr),
    .loc_we           (loc_we),
    .loc_wdata        (loc_wdata),
    .loc_rdata        (loc_rdata),
    .out_flag_wr_done (out_flag_wr_done),
    .out_flag_rd_done (out_flag_rd_done),
    .out_flag_error   (out_flag_error)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    if (a >= 8'(DEPTH)) return 8'h00;
    return model_rf[a[3:0]];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model_rf[i] = 8'h00;
  endtask

  task automatic peek(input int idx, input string tag);
    loc_addr = 4'(idx);
    #1;
    chk(tag, loc_rdata, model_rf[idx]);
  endtask

  task automatic loc_write(input logic [3:0] la, input logic [7:0] ld);
    loc_addr  = la;
    loc_wdata = ld;
    loc_we    = 1'b1;
    tick(1);
    loc_we    = 1'b0;
    model_rf[la] = ld;
  endtask

  task automatic addr_phase(input logic [7:0] a);
    in_cs = 1'b0; in_a_d = 1'b0; in_rd = 1'b1; in_wr = 1'b0; in_dato = a;
    tick(3);
    in_wr = 1'b1;
    tick(3);
    cur_addr = a;
  endtask

  // Data phase with WR; optional local write lands on the same edge as the bus commit.
  task automatic data_write(input logic [7:0] d, input bit lw, input logic [3:0] la,
                            input logic [7:0] ld);
    bit in_range;
    in_cs = 1'b0; in_a_d = 1'b1; in_rd = 1'b1; in_dato = d; in_wr = 1'b0;
    tick(3);
    in_wr = 1'b1;
    tick(1);
    chk("wr_done_early", 8'(out_flag_wr_done), 8'h00);
    if (lw) begin
      loc_addr = la; loc_wdata = ld; loc_we = 1'b1;
    end
    tick(1);
    loc_we = 1'b0;
    chk("wr_done_pulse", 8'(out_flag_wr_done), 8'h01);
    chk("wr_no_error", 8'(out_flag_error), 8'h00);
    tick(1);
    chk("wr_done_single", 8'(out_flag_wr_done), 8'h00);
    in_range = (cur_addr < 8'(DEPTH));
    if (in_range) model_rf[cur_addr[3:0]] = d;
    if (lw && !(in_range && (la == cur_addr[3:0]))) model_rf[la] = ld;
    in_cs = 1'b1;
    tick(2);
    peek(int'(cur_addr[3:0]), "wr_regfile");
    if (lw) peek(int'(la), "wr_loc_regfile");
  endtask

  // Data phase with RD; optional local write to the addressed entry while it is driven.
  task automatic data_read(input bit lw, input logic [7:0] ld);
    in_cs = 1'b0; in_a_d = 1'b1; in_wr = 1'b1; in_rd = 1'b0;
    tick(1);
    chk("rd_oe_latency", 8'(out_oe), 8'h00);
    tick(1);
    chk("rd_oe", 8'(out_oe), 8'h01);
    chk("rd_data", out_dato, exp_rd(cur_addr));
    tick(1);
    if (lw) begin
      loc_write(cur_addr[3:0], ld);
      chk("rd_local_update", out_dato, exp_rd(cur_addr));
    end
    in_rd = 1'b1;
    tick(1);
    chk("rd_oe_hold", 8'(out_oe), 8'h01);
    tick(1);
    chk("rd_oe_release", 8'(out_oe), 8'h00);
    chk("rd_done_pulse", 8'(out_flag_rd_done), 8'h01);
    tick(1);
    chk("rd_done_single", 8'(out_flag_rd_done), 8'h00);
    chk("rd_no_error", 8'(out_flag_error), 8'h00);
    in_cs = 1'b1;
    tick(2);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_oe"}, 8'(out_oe), 8'h00);
    chk({tag, "_dato"}, out_dato, 8'h00);
    chk({tag, "_flags"}, {5'b0, out_flag_wr_done, out_flag_rd_done, out_flag_error}, 8'h00);
  endtask

  initial begin
    bit         have_addr;
    logic [7:0] a;
    logic [7:0] d;
    logic [3:0] la;

    reset = 1'b1;
    in_a_d = 1'b1; in_cs = 1'b1; in_wr = 1'b1; in_rd = 1'b1; in_dato = 8'h00;
    loc_addr = '0; loc_we = 1'b0; loc_wdata = 8'h00;
    cur_addr = 8'h00;
    model_clear();
    tick(3);
    reset = 1'b0;
    tick(1);
    check_idle_outputs("reset");
    for (int i = 0; i < int'(DEPTH); i++) peek(i, "reset_regfile");

    // Write then read back over the bus.
    addr_phase(8'h03);
    data_write(8'h5A, 1'b0, 4'h0, 8'h00);
    data_read(1'b0, 8'h00);

    // Address retained across two read data phases; local updates in between and during.
    addr_phase(8'h07);
    data_read(1'b0, 8'h00);
    loc_write(4'h7, 8'hC3);
    data_read(1'b1, 8'h3C);
    peek(7, "retain_regfile");

    // Out-of-range address: write dropped, read returns zero.
    addr_phase(8'h13);
    data_write(8'hFF, 1'b0, 4'h0, 8'h00);
    peek(3, "oor_entry3");
    data_read(1'b0, 8'h00);

    // Collisions between bus commit and local write.
    addr_phase(8'h05);
    data_write(8'h11, 1'b1, 4'h5, 8'h22);
    addr_phase(8'h05);
    data_write(8'h33, 1'b1, 4'h6, 8'h22);

    // WR and RD low together in ADDR_VALID.
    addr_phase(8'h05);
    in_a_d = 1'b1; in_dato = 8'hEE; in_wr = 1'b0; in_rd = 1'b0;
    tick(1);
    chk("dbl_err_early", 8'(out_flag_error), 8'h00);
    tick(1);
    chk("dbl_err_pulse", 8'(out_flag_error), 8'h01);
    chk("dbl_oe", 8'(out_oe), 8'h00);
    tick(1);
    chk("dbl_err_single", 8'(out_flag_error), 8'h00);
    tick(2);
    in_wr = 1'b1; in_rd = 1'b1;
    tick(3);
    chk("dbl_no_commit_flag", 8'(out_flag_wr_done), 8'h00);
    in_cs = 1'b1;
    tick(3);
    peek(5, "dbl_no_commit");

    // Address phase aborted by CS, then data-phase RD from IDLE is an error.
    in_cs = 1'b0; in_a_d = 1'b0; in_wr = 1'b0; in_dato = 8'h09;
    tick(3);
    in_cs = 1'b1;
    tick(2);
    in_wr = 1'b1;
    tick(2);
    in_cs = 1'b0; in_a_d = 1'b1; in_rd = 1'b0;
    tick(1);
    chk("idle_err_early", 8'(out_flag_error), 8'h00);
    tick(1);
    chk("idle_err_pulse", 8'(out_flag_error), 8'h01);
    chk("idle_err_oe", 8'(out_oe), 8'h00);
    tick(1);
    chk("idle_err_single", 8'(out_flag_error), 8'h00);
    in_rd = 1'b1;
    tick(2);
    in_rd = 1'b0;
    tick(4);
    chk("err_hold_oe", 8'(out_oe), 8'h00);
    chk("err_hold_no_pulse", 8'(out_flag_error), 8'h00);
    in_rd = 1'b1; in_cs = 1'b1;
    tick(3);
    addr_phase(8'h0B);
    data_write(8'h6D, 1'b0, 4'h0, 8'h00);
    data_read(1'b0, 8'h00);

    // Randomized traffic against the model.
    have_addr = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if (($urandom_range(0, 2) == 0) || !have_addr) begin
        a = 8'($urandom_range(0, 31));
        addr_phase(a);
        have_addr = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) begin
        d  = 8'($urandom);
        la = 4'($urandom_range(0, 15));
        data_write(d, 1'($urandom_range(0, 1)), la, 8'($urandom));
      end else begin
        data_read(1'($urandom_range(0, 1)), 8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) begin
        la = 4'($urandom_range(0, 15));
        loc_write(la, 8'($urandom));
        peek(int'(la), "rand_local");
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) peek(i, "rand_final");

    // Reset in the middle of a WRITE data phase.
    addr_phase(8'h02);
    in_a_d = 1'b1; in_dato = 8'h77; in_wr = 1'b0;
    tick(3);
    reset = 1'b1;
    in_cs = 1'b1; in_wr = 1'b1; in_rd = 1'b1;
    tick(2);
    reset = 1'b0;
    model_clear();
    check_idle_outputs("midreset");
    tick(3);
    check_idle_outputs("postreset");
    for (int i = 0; i < int'(DEPTH); i++) peek(i, "postreset_regfile");
    addr_phase(8'h0A);
    data_write(8'h9C, 1'b0, 4'h0, 8'h00);
    data_read(1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Responder (slave) end of the multiplexed RTC parallel bus: decodes the active-low A/D, CS, WR and RD strobes issued by the bus-initiator FSM, latches the address, then commits write data to or returns read data from an internal byte register file. It sits in the RTC model and bench environment opposite the initiator and drives the shared data bus through an output-enable handed to the top-level tristate. A local port lets the timekeeping core read and update the same registers.

## Interface
- ADDR_W, 4: register-file index width; depth = 2^ADDR_W bytes.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_a_d  in  1  bus A/D strobe; 0 = address phase, 1 = data phase.
- in_cs  in  1  chip select, active-low.
- in_wr  in  1  write strobe, active-low.
- in_rd  in  1  read strobe, active-low.
- in_dato  in  8  data bus value seen at the pins.
- out_dato  out  8  read data to drive onto the bus.
- out_oe  out  1  bus drive enable for the top-level tristate.
- loc_addr  in  ADDR_W  local port register index.
- loc_we  in  1  local write enable.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  combinational regfile[loc_addr].
- out_flag_wr_done  out  1  one-cycle pulse: bus write committed.
- out_flag_rd_done  out  1  one-cycle pulse: bus read completed.
- out_flag_error  out  1  one-cycle pulse: protocol violation.

## Operation
- All bus inputs are registered once (s_a_d, s_cs, s_wr, s_rd, s_dato). The FSM acts only on the sampled values.
- FSM states are IDLE, ADDR, ADDR_VALID, WRITE, READ and ERR.
- IDLE:
  - s_cs=0, s_a_d=0, s_wr=0, s_rd=1 -> ADDR.
  - s_cs=0 with any data-phase strobe (s_a_d=1 and s_wr=0 or s_rd=0) -> error pulse, then ERR.
- ADDR:
  - The address register loads s_dato every cycle while s_wr=0.
  - s_wr=1 -> ADDR_VALID.
  - s_cs=1 before s_wr=1 -> IDLE, with no address valid.
- ADDR_VALID:
  - s_cs=0, s_a_d=1, s_wr=0 -> WRITE.
  - s_cs=0, s_a_d=1, s_rd=0 -> READ.
  - s_cs=0, s_a_d=0, s_wr=0 -> ADDR (re-address).
  - The address is retained across accesses until re-addressed or reset.
- WRITE:
  - The data register loads s_dato every cycle while s_wr=0.
  - On s_wr=1 or s_cs=1: commit data to regfile[addr[ADDR_W-1:0]], pulse wr_done, go to ADDR_VALID.
- READ:
  - out_oe=1 and out_dato=regfile[addr].
  - On s_rd=1 or s_cs=1: pulse rd_done, go to ADDR_VALID.
- Out of range: when addr[7:ADDR_W]≠0, writes are dropped (wr_done still pulses) and reads return 8'h00.
- ERR: waits for s_cs=1, then IDLE. No regfile access.
- Simultaneous s_wr=0 and s_rd=0 with s_cs=0, in any state: error pulse, out_oe forced 0, go to ERR.
- Local port:
  - loc_we writes regfile[loc_addr] on the clock edge.
  - If a bus commit targets the same index in the same cycle, the bus wins and the local write is lost.
  - Different indices both write.
- Reset:
  - state=IDLE; s_cs/s_wr/s_rd/s_a_d=1; s_dato=0.
  - Address and data registers=0; every regfile entry=8'h00.
  - out_oe=0, out_dato=0, all flags=0.
  - Reset mid-access aborts immediately; no commit.

## Timing
- Pin to state: a pin change at edge k is sampled at k, and the state updates at edge k+1.
- Read: RD falls at the pins before edge k, so out_oe=1 from edge k+1. RD rises before edge j, so out_oe=0 from edge j+1.
- out_dato is valid in the same cycle as out_oe. A local write to the addressed entry during READ is visible on out_dato the next cycle.
- Write: WR rises before edge j, so the regfile is updated at edge j+1. out_flag_wr_done is high for exactly the cycle following edge j+1.
- out_flag_rd_done is high for the one cycle following exit from READ.
- Flags are registered, single-cycle, and never overlap.
- The initiator must hold each strobe level for ≥2 clk cycles. Shorter pulses are not guaranteed to be seen.
- loc_rdata is combinational with zero latency.

## Test plan
- Write then read:
  - Bus write 8'h5A to address 8'h03 (address phase, then data phase with WR).
  - Required: wr_done pulses once and loc_rdata at loc_addr=3 reads 8'h5A.
  - A following RD phase gives out_oe=1 with out_dato=8'h5A, then rd_done pulses.
- Address retention: after addressing 8'h07, perform two consecutive read data phases without re-addressing -> both return regfile[7]; the second is preceded by a local write of 8'hC3 to index 7 and returns 8'hC3.
- Out of range: bus write 8'hFF to address 8'h13 (ADDR_W=4) -> regfile[3] unchanged and wr_done pulses. A read of 8'h13 -> out_dato=8'h00.
- Protocol errors:
  - CS=0, A/D=1, RD=0 from IDLE -> error pulse, out_oe stays 0, state ERR until CS=1.
  - WR=0 and RD=0 together in ADDR_VALID -> error pulse and no commit.
- Collision: bus commit of 8'h11 and loc_we of 8'h22 to index 5 in the same cycle -> regfile[5]=8'h11. Same test on different indices -> both written.
- Reset during a WRITE data phase -> no commit, every entry reads 8'h00, out_oe=0, flags 0, and a fresh transaction completes normally.
